// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB first, optional parity,
// 1 or 2 stop bits. Registered outputs; busy spans the frame, done pulses once after it.
module uart_tx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 out,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par, par_next;
    logic                 out_next, busy_next, done_next;
    logic                 bit_end;

    assign bit_end = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            out   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
            par   <= par_next;
            out   <= out_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        par_next   = par;
        out_next   = out;
        busy_next  = busy;
        done_next  = 1'b0;

        if (state != IDLE) begin
            cnt_next = bit_end ? '0 : cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                out_next  = 1'b1;
                busy_next = 1'b0;
                if (enable && start) begin
                    shreg_next = data_in;
                    // parity is fixed at acceptance since the word is shifted out later
                    par_next   = (^data_in) ^ (PARITY_ODD != 0);
                    out_next   = 1'b0;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_next   = '0;
                    out_next   = shreg[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_next = '0;
                        if (PARITY_EN != 0) begin
                            out_next   = par;
                            state_next = PARITY;
                        end else begin
                            out_next   = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        idx_next   = idx + 1'b1;
                        shreg_next = {1'b0, shreg[DATA_BITS-1:1]};
                        out_next   = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    idx_next   = '0;
                    out_next   = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                out_next = 1'b1;
                if (bit_end) begin
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_next   = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                out_next   = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances at CLK_DIV=4 covering default,
// even/odd parity and 7-bit/2-stop frames, with hand-computed bit sequences.
module tb_uart_tx_param;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] start_v;
    logic [7:0] data_in;
    logic [3:0] out_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int checks = 0;
    int errors = 0;

    uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .start(start_v[0]), .data_in(data_in),
        .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .start(start_v[1]), .data_in(data_in),
        .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .enable(enable), .start(start_v[2]), .data_in(data_in),
        .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    uart_tx_param #(.DATA_BITS(7), .CLK_DIV(4), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .enable(enable), .start(start_v[3]), .data_in(data_in[6:0]),
        .out(out_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int s);
        check({tag, ".out"},  32'(out_v[s]),  32'd1);
        check({tag, ".busy"}, 32'(busy_v[s]), 32'd0);
        check({tag, ".done"}, 32'(done_v[s]), 32'd0);
    endtask

    // Called just after a negedge; returns just after the accept edge.
    task automatic launch(input int s, input logic [7:0] d);
        data_in    = d;
        start_v[s] = 1'b1;
        @(posedge clk);
        #1 start_v[s] = 1'b0;
    endtask

    // exp holds the frame bits, first transmitted bit in exp[0]; nb bits of 4 cycles each.
    task automatic watch_frame(input string tag, input int s, input logic [15:0] exp,
                               input int nb, input int poke, input bit chain,
                               input logic [7:0] chain_data);
        int len;
        len = nb * 4;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            check($sformatf("%s.out%0d", tag, k),  32'(out_v[s]),  32'(exp[k / 4]));
            check($sformatf("%s.busy%0d", tag, k), 32'(busy_v[s]), 32'd1);
            check($sformatf("%s.done%0d", tag, k), 32'(done_v[s]), 32'd0);
            if (k == poke) begin
                start_v[s] = 1'b1;
                data_in    = 8'hFF;
            end
            if (k == poke + 1) start_v[s] = 1'b0;
            if (chain && k == len - 1) begin
                start_v[s] = 1'b1;
                data_in    = chain_data;
            end
        end
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done_v[s]), 32'd1);
        check({tag, ".busy_end"},   32'(busy_v[s]), 32'd0);
        check({tag, ".out_end"},    32'(out_v[s]),  32'd1);
        if (chain) begin
            @(posedge clk);
            #1 start_v[s] = 1'b0;
        end else begin
            @(negedge clk);
            check({tag, ".done_clear"}, 32'(done_v[s]), 32'd0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        start_v = '0;
        data_in = '0;
        #2;
        for (int s = 0; s < 4; s++) check_idle($sformatf("reset_u%0d", s), s);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5: 0,1,0,1,0,0,1,0,1,1
        launch(0, 8'hA5);
        watch_frame("a5", 0, 16'h034A, 10, -10, 1'b0, 8'h00);

        // 0x07 with parity: even -> 1, odd -> 0
        launch(1, 8'h07);
        watch_frame("par_even", 1, 16'h060E, 11, -10, 1'b0, 8'h00);
        launch(2, 8'h07);
        watch_frame("par_odd", 2, 16'h040E, 11, -10, 1'b0, 8'h00);

        // 7 data bits 0x55, two stop bits
        launch(3, 8'h55);
        watch_frame("stop2", 3, 16'h03AA, 10, -10, 1'b0, 8'h00);

        // mid-frame start ignored; start held through done chains 0x0F
        launch(0, 8'h3C);
        watch_frame("chain1", 0, 16'h0278, 10, 10, 1'b1, 8'h0F);
        watch_frame("chain2", 0, 16'h021E, 10, -10, 1'b0, 8'h00);

        // enable low blocks acceptance
        enable     = 1'b0;
        start_v[0] = 1'b1;
        data_in    = 8'h5A;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_idle($sformatf("disabled%0d", k), 0);
        end
        start_v[0] = 1'b0;
        enable     = 1'b1;
        @(negedge clk);

        // reset during data bit 3 (A5 bit3 = 0)
        launch(0, 8'hA5);
        repeat (17) @(negedge clk);
        check("rst_pre.out", 32'(out_v[0]), 32'd0);
        check("rst_pre.busy", 32'(busy_v[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_idle("rst_async", 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_idle($sformatf("post_rst%0d", k), 0);
        end
        launch(0, 8'hA5);
        watch_frame("after_rst", 0, 16'h034A, 10, -10, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
